// File: rtl/xnor_serial_cmp_ctrl_pkg.sv
// Shared types and width helpers for the bit-serial word-equality controller.
package xnor_serial_cmp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int idx_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/xnor_serial_cmp_ctrl_if.sv
// Start/busy/done handshake and result bus of the serial comparator.
interface xnor_serial_cmp_ctrl_if #(
  parameter int WIDTH = 8
);
  import xnor_serial_cmp_ctrl_pkg::*;

  localparam int IDXW = idx_w(WIDTH);
  localparam int CNTW = cnt_w(WIDTH);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             equal;
  logic [IDXW-1:0]  mismatch_idx;
  logic [CNTW-1:0]  mismatch_cnt;

  modport master (
    output start, a_in, b_in,
    input  busy, done, equal, mismatch_idx, mismatch_cnt
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, equal, mismatch_idx, mismatch_cnt
  );

endinterface

// File: rtl/xnor_serial_cmp_ctrl_xnor_gate.sv
// Single-bit equality gate; an unknown input bit is reported as a mismatch.
module xnor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  // An if on an X condition takes the else branch, so X/Z yields y=0.
  always_comb begin
    y = 1'b0;
    if (a ~^ b) begin
      y = 1'b1;
    end
  end

endmodule

// File: rtl/xnor_serial_cmp_ctrl.sv
// Bit-serial word comparator: one xnor_gate time-shared over WIDTH bits, LSB first.
module xnor_serial_cmp_ctrl
  import xnor_serial_cmp_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  xnor_serial_cmp_ctrl_if.slave bus
);

  localparam int              IDXW     = idx_w(WIDTH);
  localparam int              CNTW     = cnt_w(WIDTH);
  localparam logic [IDXW-1:0] LAST_BIT = IDXW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [IDXW-1:0]  r_bit_ctr;
  logic [IDXW-1:0]  r_idx_acc;
  logic [CNTW-1:0]  r_cnt_acc;
  logic             r_eq_acc;
  logic             r_first_seen;
  logic             r_busy;
  logic             r_done;
  logic             r_equal;
  logic [IDXW-1:0]  r_mismatch_idx;
  logic [CNTW-1:0]  r_mismatch_cnt;

  logic             w_y;
  logic             w_mis;
  logic             w_exit;
  logic             w_accept;
  logic             w_eq_next;
  logic             w_first_next;
  logic [IDXW-1:0]  w_idx_next;
  logic [CNTW-1:0]  w_cnt_next;

  xnor_gate u_xnor (
    .a (r_sh_a[0]),
    .b (r_sh_b[0]),
    .y (w_y)
  );

  // Accumulator values including the bit currently at the gate, so the
  // result registers can be loaded on the same edge that leaves SHIFT.
  always_comb begin
    w_mis        = ~w_y;
    w_eq_next    = r_eq_acc & w_y;
    w_cnt_next   = w_mis ? (r_cnt_acc + CNTW'(1)) : r_cnt_acc;
    w_idx_next   = (w_mis && !r_first_seen) ? r_bit_ctr : r_idx_acc;
    w_first_next = r_first_seen | w_mis;
    w_exit       = (r_bit_ctr == LAST_BIT) || (EARLY_EXIT && w_mis);
    w_accept     = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_sh_a         <= '0;
      r_sh_b         <= '0;
      r_bit_ctr      <= '0;
      r_idx_acc      <= '0;
      r_cnt_acc      <= '0;
      r_eq_acc       <= 1'b0;
      r_first_seen   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_equal        <= 1'b0;
      r_mismatch_idx <= '0;
      r_mismatch_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_SHIFT: begin
          r_eq_acc     <= w_eq_next;
          r_cnt_acc    <= w_cnt_next;
          r_idx_acc    <= w_idx_next;
          r_first_seen <= w_first_next;
          r_sh_a       <= {1'b0, r_sh_a[WIDTH-1:1]};
          r_sh_b       <= {1'b0, r_sh_b[WIDTH-1:1]};
          r_bit_ctr    <= r_bit_ctr + IDXW'(1);
          if (w_exit) begin
            r_state        <= ST_DONE;
            r_busy         <= 1'b0;
            r_done         <= 1'b1;
            r_equal        <= w_eq_next;
            r_mismatch_idx <= w_idx_next;
            r_mismatch_cnt <= w_cnt_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Capture from IDLE or DONE; overrides the fall-back to IDLE above.
      if (w_accept) begin
        r_state      <= ST_SHIFT;
        r_busy       <= 1'b1;
        r_sh_a       <= bus.a_in;
        r_sh_b       <= bus.b_in;
        r_bit_ctr    <= '0;
        r_idx_acc    <= '0;
        r_cnt_acc    <= '0;
        r_eq_acc     <= 1'b1;
        r_first_seen <= 1'b0;
      end
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.equal        = r_equal;
  assign bus.mismatch_idx = r_mismatch_idx;
  assign bus.mismatch_cnt = r_mismatch_cnt;

endmodule
